// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU scheduler slice.
//   N_REQ        number of requesters sharing the ALU
//   ALU_*        3-bit ALU function codes
//   state_e      sequencer state encoding (IDLE/EXEC/RESP)
package alu_pkg;

  localparam int N_REQ = 2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SRL  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: 2-way arbiter producing a one-hot grant.
// Optional macro: ALU_SCHED_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a contest, no pointer state
//   undefined -> round-robin on a last-served pointer (resets to 1)
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous reset, active-low
//   valid_i   request valid per requester
//   update_i  strobe: the current grant was accepted, advance pointer
//   grant_o   one-hot grant, zero when nothing is valid
module alu_rr_arb
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] valid_i,
  input  logic             update_i,
  output logic [N_REQ-1:0] grant_o
);

`ifdef ALU_SCHED_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk_i, rst_ni, update_i};

  always_comb begin
    grant_o = '0;
    if (valid_i[0])      grant_o = 2'b01;
    else if (valid_i[1]) grant_o = 2'b10;
  end

`else

  // Index of the requester served most recently.
  logic last_q;
  logic last_d;

  always_comb begin
    grant_o = valid_i;
    // On contention, favour the one not served last.
    if (valid_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
  end

  assign last_d = update_i ? grant_o[1] : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

`endif

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one SISD ALU between two requesters. Accepts an
// operation over valid/ready, drives the ALU bus for LATENCY cycles,
// captures result plus flags and returns them to the issuing requester.
// Optional macro: ALU_SCHED_FIXED_PRIO_EN (fixed priority, see alu_rr_arb).
// Parameters: WIDTH operand width, LATENCY ALU hold cycles (>=1).
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req_valid/o_req_ready   per-requester request handshake
//   i_s1, i_s2, i_func        operands/function, {req1, req0}
//   o_resp_valid/i_resp_ready per-requester response handshake
//   o_result, o_zero, o_negative, o_overflow   captured result and flags
//   o_alu_en, o_alu_s1, o_alu_s2, o_alu_func   ALU drive bus
//   i_alu_result, i_alu_overflow               ALU return
//
// state | meaning
// IDLE  | waiting for a request, o_req_ready follows the arbiter
// EXEC  | ALU enabled, counting LATENCY cycles, capture on last count
// RESP  | response held to owner until its i_resp_ready
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [2*WIDTH-1:0]   i_s1,
  input  logic [2*WIDTH-1:0]   i_s2,
  input  logic [5:0]           i_func,
  output logic [N_REQ-1:0]     o_resp_valid,
  input  logic [N_REQ-1:0]     i_resp_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_zero,
  output logic                 o_negative,
  output logic                 o_overflow,
  output logic                 o_alu_en,
  output logic [WIDTH-1:0]     o_alu_s1,
  output logic [WIDTH-1:0]     o_alu_s2,
  output logic [2:0]           o_alu_func,
  input  logic [WIDTH-1:0]     i_alu_result,
  input  logic                 i_alu_overflow
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               owner_q;
  logic [N_REQ-1:0]   resp_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               neg_q;
  logic               ovf_q;
  logic               alu_en_q;
  logic [WIDTH-1:0]   alu_s1_q;
  logic [WIDTH-1:0]   alu_s2_q;
  logic [2:0]         alu_func_q;

  logic [N_REQ-1:0]   gnt;
  logic               accept;
  logic               acc_id;

  alu_rr_arb u_arb (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .valid_i  (i_req_valid),
    .update_i (accept),
    .grant_o  (gnt)
  );

  // Gated by reset so the port reads 0 while reset is held.
  assign o_req_ready = (state_q == IDLE && i_rst_n) ? gnt : '0;
  assign accept      = |(i_req_valid & o_req_ready);
  assign acc_id      = gnt[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      resp_valid_q <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_s1_q     <= '0;
      alu_s2_q     <= '0;
      alu_func_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Operands go straight onto the ALU bus; they then hold
            // there after EXEC until the next accept.
            owner_q    <= acc_id;
            alu_s1_q   <= acc_id ? i_s1[2*WIDTH-1:WIDTH] : i_s1[WIDTH-1:0];
            alu_s2_q   <= acc_id ? i_s2[2*WIDTH-1:WIDTH] : i_s2[WIDTH-1:0];
            alu_func_q <= acc_id ? i_func[5:3] : i_func[2:0];
            alu_en_q   <= 1'b1;
            cnt_q      <= '0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == CNT_LAST) begin
            result_q     <= i_alu_result;
            ovf_q        <= i_alu_overflow;
            zero_q       <= (i_alu_result == '0);
            neg_q        <= i_alu_result[WIDTH-1];
            alu_en_q     <= 1'b0;
            resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            cnt_q        <= '0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (i_resp_ready[owner_q]) begin
            resp_valid_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_resp_valid = resp_valid_q;
  assign o_result     = result_q;
  assign o_zero       = zero_q;
  assign o_negative   = neg_q;
  assign o_overflow   = ovf_q;
  assign o_alu_en     = alu_en_q;
  assign o_alu_s1     = alu_s1_q;
  assign o_alu_s2     = alu_s2_q;
  assign o_alu_func   = alu_func_q;

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

  localparam int W   = 8;
  localparam int LAT = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [1:0]    i_req_valid;
  logic [1:0]    o_req_ready;
  logic [2*W-1:0] i_s1, i_s2;
  logic [5:0]    i_func;
  logic [1:0]    o_resp_valid;
  logic [1:0]    i_resp_ready;
  logic [W-1:0]  o_result;
  logic          o_zero, o_negative, o_overflow;
  logic          o_alu_en;
  logic [W-1:0]  o_alu_s1, o_alu_s2;
  logic [2:0]    o_alu_func;
  logic [W-1:0]  i_alu_result;
  logic          i_alu_overflow;

  int n_chk = 0;
  int n_fail = 0;

  alu_sched #(.WIDTH(W), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_s1(i_s1), .i_s2(i_s2), .i_func(i_func),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_result(o_result), .o_zero(o_zero), .o_negative(o_negative),
    .o_overflow(o_overflow), .o_alu_en(o_alu_en),
    .o_alu_s1(o_alu_s1), .o_alu_s2(o_alu_s2), .o_alu_func(o_alu_func),
    .i_alu_result(i_alu_result), .i_alu_overflow(i_alu_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural ALU: {carry, result} for a function code.
  function automatic logic [8:0] alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Slow ALU emulation: the return bus is only correct in the last
  // enabled cycle, so early or late capture shows up as a wrong result.
  int en_cnt = 0;
  always @(posedge i_clk) en_cnt <= o_alu_en ? en_cnt + 1 : 0;

  logic [8:0] alu_full;
  always_comb begin
    alu_full = alu_ref(o_alu_func, o_alu_s1, o_alu_s2);
    if (en_cnt != LAT - 1) alu_full = alu_full ^ 9'h1A5;
  end
  assign i_alu_result   = alu_full[7:0];
  assign i_alu_overflow = alu_full[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration state: index of last served requester.
  int last_srv = 1;

  function automatic logic [1:0] ref_grant(input logic [1:0] v);
    if (v != 2'b11) return v;
`ifdef ALU_SCHED_FIXED_PRIO_EN
    return 2'b01;
`else
    return (last_srv == 1) ? 2'b01 : 2'b10;
`endif
  endfunction

  logic [7:0] oa [2];
  logic [7:0] ob [2];
  logic [2:0] of [2];

  task automatic rand_ops();
    for (int r = 0; r < 2; r++) begin
      oa[r] = 8'($urandom);
      ob[r] = 8'($urandom);
      of[r] = 3'($urandom_range(0, 5));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"},  o_req_ready, 0);
    chk({tag, "_resp_valid"}, o_resp_valid, 0);
    chk({tag, "_result"},     o_result, 0);
    chk({tag, "_zero"},       o_zero, 0);
    chk({tag, "_negative"},   o_negative, 0);
    chk({tag, "_overflow"},   o_overflow, 0);
    chk({tag, "_alu_en"},     o_alu_en, 0);
    chk({tag, "_alu_s1"},     o_alu_s1, 0);
    chk({tag, "_alu_s2"},     o_alu_s2, 0);
    chk({tag, "_alu_func"},   o_alu_func, 0);
  endtask

  // One full transaction, entered and left at a falling edge.
  task automatic run_op(input logic [1:0] vld, input int bp, input bit keep, output int who);
    logic [1:0] g;
    logic [8:0] e;
    i_s1 = {oa[1], oa[0]};
    i_s2 = {ob[1], ob[0]};
    i_func = {of[1], of[0]};
    i_req_valid = vld;
    #1;
    g = ref_grant(vld);
    chk("req_ready", o_req_ready, g);
    who = g[1] ? 1 : 0;
    e = alu_ref(of[who], oa[who], ob[who]);
    @(posedge i_clk);
    last_srv = who;
    for (int c = 0; c < LAT; c++) begin
      @(negedge i_clk);
      chk("alu_en", o_alu_en, 1);
      chk("alu_s1", o_alu_s1, oa[who]);
      chk("alu_s2", o_alu_s2, ob[who]);
      chk("alu_func", o_alu_func, of[who]);
      chk("resp_valid_exec", o_resp_valid, 0);
      chk("req_ready_exec", o_req_ready, 0);
      if (!keep) i_req_valid = 2'b00;
    end
    @(negedge i_clk);
    chk("alu_en_resp", o_alu_en, 0);
    chk("resp_valid", o_resp_valid, g);
    chk("result", o_result, e[7:0]);
    chk("overflow", o_overflow, e[8]);
    chk("zero", o_zero, (e[7:0] == 8'h00));
    chk("negative", o_negative, e[7]);
    for (int c = 0; c < bp; c++) begin
      i_resp_ready = ~g & 2'($urandom_range(0, 3));
      @(negedge i_clk);
      chk("bp_resp_valid", o_resp_valid, g);
      chk("bp_result", o_result, e[7:0]);
      chk("bp_req_ready", o_req_ready, 0);
    end
    i_resp_ready = g | (~g & 2'($urandom_range(0, 3)));
    @(negedge i_clk);
    i_resp_ready = 2'b00;
    chk("resp_done", o_resp_valid, 0);
  endtask

  int who;
  logic [1:0] v;

  initial begin
    // Reset with random inputs
    i_rst_n      = 1'b0;
    i_req_valid  = 2'($urandom);
    i_resp_ready = 2'($urandom);
    i_s1 = 16'($urandom);
    i_s2 = 16'($urandom);
    i_func = 6'($urandom);
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_req_valid  = 2'b00;
    i_resp_ready = 2'b00;
    i_rst_n      = 1'b1;
    @(negedge i_clk);
    chk("idle_no_valid", o_req_ready, 0);

    // Directed single ops and flag corners
    rand_ops();
    oa[0] = 8'h0F; ob[0] = 8'h01; of[0] = 3'd0;
    run_op(2'b01, 0, 1'b0, who);
    oa[1] = 8'hFF; ob[1] = 8'h01; of[1] = 3'd0;
    run_op(2'b10, 0, 1'b0, who);
    oa[1] = 8'h7F; ob[1] = 8'h01; of[1] = 3'd0;
    run_op(2'b10, 0, 1'b0, who);

    // Backpressure with non-owner ready toggling
    rand_ops();
    run_op(2'b01, 5, 1'b0, who);

    // Reset in the first EXEC cycle aborts the operation
    rand_ops();
    i_s1 = {oa[1], oa[0]};
    i_s2 = {ob[1], ob[0]};
    i_func = {of[1], of[0]};
    i_req_valid = 2'b01;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("abort_alu_en_before", o_alu_en, 1);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    last_srv = 1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req_valid = 2'b00;
    repeat (LAT + 3) begin
      @(negedge i_clk);
      chk("abort_no_resp", o_resp_valid, 0);
      chk("abort_alu_idle", o_alu_en, 0);
    end

    // Contention: both valid continuously
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      run_op(2'b11, 0, 1'b1, who);
`ifdef ALU_SCHED_FIXED_PRIO_EN
      chk("contention_order", who, 0);
`else
      chk("contention_order", who, k % 2);
`endif
    end
    i_req_valid = 2'b00;
    #1;
    chk("idle_after_contention", o_req_ready, 0);
    @(negedge i_clk);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      rand_ops();
      v = 2'($urandom_range(1, 3));
      run_op(v, $urandom_range(0, 3), 1'($urandom), who);
      if ($urandom_range(0, 2) == 0) begin
        i_req_valid = 2'b00;
        #1;
        chk("gap_req_ready", o_req_ready, 0);
        @(negedge i_clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Sequencer and arbiter that shares the single SISD ALU between two requesters, e.g. the execute stage (requester 0) and the address/PC-update path (requester 1). It accepts operations over a valid/ready handshake, grants one at a time, drives the ALU operand/function bus for a configurable number of cycles, and captures the result. It returns the result to the issuing requester, with zero/negative flags derived locally and overflow taken from the ALU carry.

## Interface
- WIDTH, 8, operand/result width
- LATENCY, 1, cycles the ALU inputs are held before capture (≥1; >1 models the SLOW ALU)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous reset, active-low
- i_req_valid  in  2  request valid, bit r = requester r
- o_req_ready  out  2  request accept, one-hot or zero
- i_s1  in  2*WIDTH  operand 1, {req1, req0}
- i_s2  in  2*WIDTH  operand 2, {req1, req0}
- i_func  in  2*3  function code, {req1, req0}
- o_resp_valid  out  2  response valid, one-hot to the issuing requester
- i_resp_ready  in  2  response accept, bit r = requester r
- o_result  out  WIDTH  captured result
- o_zero / o_negative / o_overflow  out  1 each  result flags
- o_alu_en  out  1  ALU enable
- o_alu_s1 / o_alu_s2  out  WIDTH each  ALU operands
- o_alu_func  out  3  ALU function
- i_alu_result  in  WIDTH  ALU result
- i_alu_overflow  in  1  ALU carry-out

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - o_req_ready = grant when any i_req_valid is set; otherwise 0.
  - On accept (valid & ready), latch s1/s2/func and the owner id, then go to EXEC.
- **Arbitration (default)**
  - Round-robin with a last-served pointer.
  - If both requesters are valid, grant the one not served last.
  - If only one is valid, grant it.
  - The pointer updates only on accept. Reset value is 1, so requester 0 wins the first contest.
- **EXEC**
  - o_alu_en = 1; o_alu_s1/s2/func drive the latched values.
  - A counter runs 0..LATENCY-1.
  - On the last count, capture the following, then go to RESP:
    - o_result = i_alu_result
    - o_overflow = i_alu_overflow
    - o_zero = (result == 0)
    - o_negative = result[WIDTH-1]
- **RESP**
  - o_resp_valid[owner] = 1.
  - Result and flags are held stable until i_resp_ready[owner] = 1; then go to IDLE.
  - i_resp_ready of the non-owner is ignored.
- **Outside EXEC**: o_alu_en = 0; ALU operand/function outputs hold their last values.
- **Requester rules**: a requester may drop or change valid while not granted. It must hold its operands while valid & ready is high.
- **Arithmetic**: no width extension. Overflow is the unsigned carry; no signed overflow is produced.

## Timing
- Reset value of every output is 0: o_req_ready, o_resp_valid, o_result, flags, o_alu_en, o_alu_s1/s2/func.
- Pointer resets to 1; FSM resets to IDLE; counter resets to 0.
- Latency: accept at edge T, o_alu_en high in cycles T+1..T+LATENCY, o_resp_valid high from cycle T+LATENCY+1.
- Throughput: at most one operation per LATENCY+2 cycles. The next accept is possible in the first IDLE cycle after the response handshake.
- o_req_ready is combinational from i_req_valid and state. No other output depends combinationally on inputs.
- Asserting reset mid-EXEC or mid-RESP aborts the operation immediately. No response is issued; the requester must re-issue.
- If a request arrives on the same edge that the response completes, it is not accepted until the following IDLE cycle.

## Configuration
- ALU_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority. Requester 0 always wins when both are valid, and the pointer logic is removed.
  - Undefined: round-robin as specified above.

## Structure
- Package alu_pkg holds:
  - ALU function-code constants (3-bit)
  - the FSM state enum (IDLE/EXEC/RESP)
  - the requester-count constant (2)
- Sub-module alu_rr_arb is a 2-way arbiter taking valid and an update strobe and returning a one-hot grant. It owns the last-served pointer, and the ALU_SCHED_FIXED_PRIO_EN selection lives inside it.

## Test plan
- Reset: hold i_rst_n=0 with random inputs → all outputs 0. After release with no valid, o_req_ready=00.
- Single op, LATENCY=1: req0 s1=0x0F s2=0x01 → accept at T, o_alu_en in T+1, o_resp_valid=01 at T+2 with result=0x10, zero=0, negative=0, overflow=0.
- Carry and flags: req1 s1=0xFF s2=0x01 → resp_valid=10, result=0x00, zero=1, overflow=1. Then s1=0x7F s2=0x01 → result=0x80, negative=1.
- Contention: both valid continuously for 4 operations → grants in order 0,1,0,1 (round-robin). With ALU_SCHED_FIXED_PRIO_EN → 0,0,0,0.
- Backpressure and LATENCY=3: hold i_resp_ready=00 for 5 cycles → resp_valid and result stay stable, o_req_ready stays 00. Raise the owner's ready → IDLE next cycle. Non-owner ready has no effect.
- Reset during EXEC: drop i_rst_n in cycle T+1 → no response ever issued, outputs return to 0, pointer returns to 1.
